// File: rtl/serial_rx.sv
// 8N1 serial receiver: fixed clocks-per-bit sampling, LSB first, sticky dataReady.
// Optional build macro SERIAL_RX_FRAME_ERROR_EN adds a frameError output.
module serial_rx #(
    parameter int counterBits = 2,
    parameter int delay       = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       serialIn,
    output logic [7:0] data,
    output logic       dataReady
`ifdef SERIAL_RX_FRAME_ERROR_EN
    ,
    output logic       frameError
`endif
);

    generate
        if (delay < 3 || (2 ** counterBits) <= delay) begin : g_param_check
            $error("serial_rx: need delay >= 3 and 2**counterBits > delay");
        end
    endgenerate

    localparam logic [counterBits-1:0] CNT_LAST = counterBits'(delay - 1);
    localparam logic [counterBits-1:0] CNT_HALF = counterBits'(delay / 2 - 1);
    localparam logic [counterBits-1:0] CNT_ONE  = counterBits'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 r_state, w_state_nxt;
    logic [counterBits-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]             r_bit_idx, w_bit_idx_nxt;
    logic [7:0]             r_shift, w_shift_nxt;
    logic [7:0]             r_data, w_data_nxt;
    logic                   r_rdy, w_rdy_nxt;
    // Cleared by a framing error so a stuck-low line cannot look like a new start bit.
    logic                   r_armed, w_armed_nxt;
`ifdef SERIAL_RX_FRAME_ERROR_EN
    logic                   r_ferr, w_ferr_nxt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_rdy     <= 1'b0;
            r_armed   <= 1'b1;
`ifdef SERIAL_RX_FRAME_ERROR_EN
            r_ferr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_rdy     <= w_rdy_nxt;
            r_armed   <= w_armed_nxt;
`ifdef SERIAL_RX_FRAME_ERROR_EN
            r_ferr    <= w_ferr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_rdy_nxt     = r_rdy;
        w_armed_nxt   = r_armed;
`ifdef SERIAL_RX_FRAME_ERROR_EN
        w_ferr_nxt    = r_ferr;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (serialIn) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_state_nxt = START;
                    w_rdy_nxt   = 1'b0;
`ifdef SERIAL_RX_FRAME_ERROR_EN
                    w_ferr_nxt  = 1'b0;
`endif
                end
            end
            START: begin
                // Mid-start-bit re-sample filters short glitches.
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt = '0;
                    if (!serialIn) begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {serialIn, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (serialIn) begin
                        w_data_nxt = r_shift;
                        w_rdy_nxt  = 1'b1;
                    end else begin
                        w_armed_nxt = 1'b0;
`ifdef SERIAL_RX_FRAME_ERROR_EN
                        w_ferr_nxt  = 1'b1;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign data      = r_data;
    assign dataReady = r_rdy;
`ifdef SERIAL_RX_FRAME_ERROR_EN
    assign frameError = r_ferr;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed scenarios plus random frames against a frame-level model.
module tb_serial_rx;
    localparam int D = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       serialIn = 1'b1;
    logic [7:0] data;
    logic       dataReady;
`ifdef SERIAL_RX_FRAME_ERROR_EN
    logic       frameError;
`endif

    int checks = 0;
    int errors = 0;

    // Frame-level model: what the outputs should be after each whole frame.
    logic [7:0] exp_data;
    logic       exp_rdy;

    always #5 clk = ~clk;

    serial_rx #(.counterBits(2), .delay(D)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .serialIn (serialIn),
        .data     (data),
        .dataReady(dataReady)
`ifdef SERIAL_RX_FRAME_ERROR_EN
        ,
        .frameError(frameError)
`endif
    );

    task automatic hold(input logic v, input int n);
        serialIn = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives a whole frame; reports outputs seen after data bit 3 for mid-frame checks.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              output logic [7:0] mid_d, output logic mid_r);
        mid_d = 8'h00;
        mid_r = 1'b0;
        hold(1'b0, D);
        for (int i = 0; i < 8; i++) begin
            hold(b[i], D);
            if (i == 3) begin
                mid_d = data;
                mid_r = dataReady;
            end
        end
        hold(stop, D);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        serialIn = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        checks++;
        if (data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", data);
        end
        checks++;
        if (dataReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy: got %b expected 0", dataReady);
        end
`ifdef SERIAL_RX_FRAME_ERROR_EN
        checks++;
        if (frameError !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr: got %b expected 0", frameError);
        end
`endif
    endtask

    task automatic test_known_frame();
        logic [7:0] md;
        logic       mr;
        send_frame(8'b0110_0101, 1'b1, md, mr);
        checks++;
        if (md !== exp_data || mr !== 1'b0) begin
            errors++;
            $display("FAIL known_mid: got %h/%b expected %h/0", md, mr, exp_data);
        end
        exp_data = 8'b0110_0101;
        exp_rdy  = 1'b1;
        checks++;
        if (data !== exp_data || dataReady !== 1'b1) begin
            errors++;
            $display("FAIL known_end: got %h/%b expected %h/1", data, dataReady, exp_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        b = 8'($urandom);
        hold(1'b0, 1);
        checks++;
        if (dataReady !== 1'b0 || data !== exp_data) begin
            errors++;
            $display("FAIL b2b_start: got %h/%b expected %h/0", data, dataReady, exp_data);
        end
        hold(1'b0, D - 1);
        for (int i = 0; i < 8; i++) hold(b[i], D);
        hold(1'b1, D);
        exp_data = b;
        exp_rdy  = 1'b1;
        checks++;
        if (data !== exp_data || dataReady !== 1'b1) begin
            errors++;
            $display("FAIL b2b_frame: got %h/%b expected %h/1", data, dataReady, exp_data);
        end
        hold(1'b1, 2);
    endtask

    task automatic test_glitch();
        hold(1'b0, 1);
        hold(1'b1, 12 * D);
        exp_rdy = 1'b0;
        checks++;
        if (dataReady !== 1'b0 || data !== exp_data) begin
            errors++;
            $display("FAIL glitch: got %h/%b expected %h/0", data, dataReady, exp_data);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] md;
        logic       mr;
        send_frame(8'hA5, 1'b0, md, mr);
        exp_rdy = 1'b0;
        checks++;
        if (data !== exp_data || dataReady !== 1'b0) begin
            errors++;
            $display("FAIL ferr_frame: got %h/%b expected %h/0", data, dataReady, exp_data);
        end
`ifdef SERIAL_RX_FRAME_ERROR_EN
        checks++;
        if (frameError !== 1'b1) begin
            errors++;
            $display("FAIL ferr_flag: got %b expected 1", frameError);
        end
`endif
        // Line stays low well past the stop bit; receiver must not re-trigger.
        hold(1'b0, 2 * D);
        hold(1'b1, 2);
        send_frame(8'h3C, 1'b1, md, mr);
        exp_data = 8'h3C;
        exp_rdy  = 1'b1;
        checks++;
        if (data !== exp_data || dataReady !== 1'b1) begin
            errors++;
            $display("FAIL ferr_recover: got %h/%b expected %h/1", data, dataReady, exp_data);
        end
`ifdef SERIAL_RX_FRAME_ERROR_EN
        checks++;
        if (frameError !== 1'b0) begin
            errors++;
            $display("FAIL ferr_clear: got %b expected 0", frameError);
        end
`endif
        hold(1'b1, 2);
    endtask

    task automatic test_async_reset();
        logic [7:0] b;
        logic [7:0] md;
        logic       mr;
        b = 8'h5A;
        hold(1'b0, D);
        for (int i = 0; i < 4; i++) hold(b[i], D);
        serialIn = b[4];
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (data !== 8'h00 || dataReady !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h/%b expected 00/0", data, dataReady);
        end
        @(negedge clk);
        serialIn = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'hFF, 1'b1, md, mr);
        exp_data = 8'hFF;
        exp_rdy  = 1'b1;
        checks++;
        if (data !== 8'hFF || dataReady !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_frame: got %h/%b expected ff/1", data, dataReady);
        end
        hold(1'b1, 2);
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] md;
        logic       mr;
        logic       stop;
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop, md, mr);
            checks++;
            if (md !== exp_data || mr !== 1'b0) begin
                errors++;
                $display("FAIL rand_mid[%0d]: got %h/%b expected %h/0", n, md, mr, exp_data);
            end
            if (stop) exp_data = b;
            exp_rdy = stop;
            checks++;
            if (data !== exp_data || dataReady !== exp_rdy) begin
                errors++;
                $display("FAIL rand_end[%0d]: got %h/%b expected %h/%b", n, data, dataReady, exp_data, exp_rdy);
            end
`ifdef SERIAL_RX_FRAME_ERROR_EN
            checks++;
            if (frameError !== !stop) begin
                errors++;
                $display("FAIL rand_ferr[%0d]: got %b expected %b", n, frameError, !stop);
            end
`endif
            hold(1'b1, $urandom_range(1, 4));
        end
    endtask

    initial begin
        test_reset();
        test_known_frame();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
